// File: rtl/udp_pkg.sv
// Shared constants for the UDP transmit framer: header size, default ports,
// one-hot FSM encoding and the wire byte-order helper.
package udp_pkg;

  localparam int UDP_HEAD_BYTES = 8;
  localparam logic [15:0] UDP_DEF_SRC_PORT = 16'd18070;
  localparam logic [15:0] UDP_DEF_DST_PORT = 16'd18070;

  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_HEAD = 3'b010;
  localparam logic [2:0] ST_DATA = 3'b100;

  // The wire takes data[7:0] first, so the network-order MSB goes to the low lane.
  function automatic logic [15:0] wire_be16(input logic [15:0] field);
    return {field[7:0], field[15:8]};
  endfunction

endpackage

// File: rtl/udp_tx.sv
// UDP transmit framer: emits an 8-byte header in four 16-bit beats, then passes
// the application payload through. Optional length checking: UDP_TX_LEN_CHK_EN.
module udp_tx
  import udp_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                LEN_W    = $clog2(DATA_W/8) + 1,
  parameter int                PORT_W   = 16,
  parameter logic [PORT_W-1:0] SRC_PORT = UDP_DEF_SRC_PORT,
  parameter logic [PORT_W-1:0] DST_PORT = UDP_DEF_DST_PORT
) (
  input  logic              clk,
  input  logic              nreset,
  // Handshakes: a transfer happens on any cycle where valid and ready are both
  // high at the rising clock edge; valid never waits on ready.
  input  logic              cmd_v_i,
  input  logic [15:0]       pay_len_i,
  output logic              cmd_rdy_o,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic              start_o,
  output logic [DATA_W-1:0] data_o,
  output logic [LEN_W-1:0]  len_o,
  output logic              last_o,
  input  logic              ready_i,
  input  logic              cancel_i,
  output logic              err_o,
  output logic [2:0]        fsm_state
);

  logic [2:0]  state_q;
  logic [1:0]  hdr_idx_q;
  logic [15:0] cnt_q;
  logic [15:0] pay_len_q;
  logic [15:0] udp_len_q;
  logic [16:0] cnt_sum;
  logic        data_last;
  logic        len_bad;
  logic        abort;
  logic [15:0] hdr_field;

  assign fsm_state = state_q;
  assign cnt_sum   = {1'b0, cnt_q} + 17'(len_i);
  assign data_last = cnt_sum >= {1'b0, pay_len_q};

`ifdef UDP_TX_LEN_CHK_EN
  logic err_q;

  // Any app beat outside DATA, a malformed len, or an overrun aborts the datagram.
  always_comb begin
    len_bad = 1'b0;
    if (valid_i) begin
      if (state_q != ST_DATA)
        len_bad = 1'b1;
      else if (len_i == '0 || len_i > LEN_W'(2) || cnt_sum > {1'b0, pay_len_q})
        len_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)
      err_q <= 1'b0;
    else if (len_bad)
      err_q <= 1'b1;
    else if (cmd_v_i && cmd_rdy_o)
      err_q <= 1'b0;
  end

  assign err_o = err_q;
`else
  assign len_bad = 1'b0;
  assign err_o   = 1'b0;
`endif

  assign abort = cancel_i | len_bad;

  always_comb begin
    hdr_field = 16'h0000;
    case (hdr_idx_q)
      2'd0:    hdr_field = 16'(SRC_PORT);
      2'd1:    hdr_field = 16'(DST_PORT);
      2'd2:    hdr_field = udp_len_q;
      default: hdr_field = 16'h0000;
    endcase
  end

  always_comb begin
    cmd_rdy_o = 1'b0;
    ready_o   = 1'b0;
    valid_o   = 1'b0;
    start_o   = 1'b0;
    data_o    = '0;
    len_o     = '0;
    last_o    = 1'b0;
    case (state_q)
      ST_IDLE: cmd_rdy_o = ~abort;
      ST_HEAD: begin
        valid_o = 1'b1;
        start_o = (hdr_idx_q == 2'd0);
        data_o  = DATA_W'(wire_be16(hdr_field));
        len_o   = LEN_W'(2);
        last_o  = (hdr_idx_q == 2'd3) && (pay_len_q == 16'd0);
      end
      ST_DATA: begin
        valid_o = valid_i;
        ready_o = ready_i;
        data_o  = data_i;
        len_o   = len_i;
        last_o  = valid_i & data_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= ST_IDLE;
      hdr_idx_q <= 2'd0;
      cnt_q     <= 16'd0;
      pay_len_q <= 16'd0;
      udp_len_q <= 16'd0;
    end else if (abort) begin
      state_q   <= ST_IDLE;
      hdr_idx_q <= 2'd0;
      cnt_q     <= 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_v_i) begin
            pay_len_q <= pay_len_i;
            udp_len_q <= pay_len_i + 16'(UDP_HEAD_BYTES);
            hdr_idx_q <= 2'd0;
            cnt_q     <= 16'd0;
            state_q   <= ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (ready_i) begin
            if (hdr_idx_q == 2'd3) begin
              hdr_idx_q <= 2'd0;
              state_q   <= (pay_len_q == 16'd0) ? ST_IDLE : ST_DATA;
            end else begin
              hdr_idx_q <= hdr_idx_q + 2'd1;
            end
          end
        end
        ST_DATA: begin
          if (valid_i && ready_i) begin
            if (data_last) begin
              cnt_q   <= 16'd0;
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_sum[15:0];
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx.sv
// Directed bench for udp_tx: header/payload framing, stalls, cancel and reset.
module tb_udp_tx;
  import udp_pkg::*;

  logic        clk = 1'b0;
  logic        nreset;
  logic        cmd_v_i;
  logic [15:0] pay_len_i;
  logic        cmd_rdy_o;
  logic        valid_i;
  logic [15:0] data_i;
  logic [1:0]  len_i;
  logic        ready_o;
  logic        valid_o;
  logic        start_o;
  logic [15:0] data_o;
  logic [1:0]  len_o;
  logic        last_o;
  logic        ready_i;
  logic        cancel_i;
  logic        err_o;
  logic [2:0]  fsm_state;

  int n_tests = 0;
  int n_fail  = 0;
  int beat_cnt = 0;
  logic [19:0] exp_q[$];

  udp_tx dut (
    .clk(clk), .nreset(nreset),
    .cmd_v_i(cmd_v_i), .pay_len_i(pay_len_i), .cmd_rdy_o(cmd_rdy_o),
    .valid_i(valid_i), .data_i(data_i), .len_i(len_i), .ready_o(ready_o),
    .valid_o(valid_o), .start_o(start_o), .data_o(data_o), .len_o(len_o),
    .last_o(last_o), .ready_i(ready_i), .cancel_i(cancel_i), .err_o(err_o),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // beat = {start, last, len[1:0], data[15:0]}
  task automatic push_beat(input logic s, input logic l, input logic [1:0] n, input logic [15:0] d);
    exp_q.push_back({s, l, n, d});
  endtask

  // scoreboard: every accepted output beat must match the head of exp_q
  always @(negedge clk) begin
    if (nreset && valid_o && ready_i) begin
      beat_cnt++;
      if (exp_q.size() == 0)
        check("unexpected_beat", exp_q.size(), 1);
      else
        check("beat", {start_o, last_o, len_o, data_o}, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic send_cmd(input logic [15:0] p);
    logic ok = 1'b0;
    cmd_v_i = 1'b1;
    pay_len_i = p;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_rdy_o) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    cmd_v_i = 1'b0;
    check("cmd_accept", ok, 1);
  endtask

  task automatic send_beat(input logic [15:0] d, input logic [1:0] n);
    logic in_data = 1'b0;
    logic ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (fsm_state == ST_DATA) begin in_data = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("reach_data", in_data, 1);
    valid_i = 1'b1;
    data_i = d;
    len_i = n;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready_o) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
    check("beat_accept", ok, 1);
  endtask

  task automatic wait_drain();
    logic ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    check("drain", ok, 1);
  endtask

  initial begin
    int base;
    nreset = 1'b0; cmd_v_i = 1'b0; pay_len_i = '0; valid_i = 1'b0;
    data_i = '0; len_i = '0; ready_i = 1'b1; cancel_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_rdy", cmd_rdy_o, 1);
    check("rst_valid", valid_o, 0);
    check("rst_ready", ready_o, 0);
    check("rst_start", start_o, 0);
    check("rst_last", last_o, 0);
    check("rst_err", err_o, 0);
    check("rst_state", fsm_state, ST_IDLE);
    nreset = 1'b1;
    @(posedge clk); #1;

    // pay_len 4, two 2-byte beats
    push_beat(1, 0, 2, 16'h9646);
    push_beat(0, 0, 2, 16'h9646);
    push_beat(0, 0, 2, 16'h0C00);
    push_beat(0, 0, 2, 16'h0000);
    push_beat(0, 0, 2, 16'h0201);
    push_beat(0, 1, 2, 16'h0403);
    send_cmd(16'd4);
    send_beat(16'h0201, 2'd2);
    send_beat(16'h0403, 2'd2);
    wait_drain();
    check("t26_idle", fsm_state, ST_IDLE);

    // pay_len 0: header only, last on beat 3
    push_beat(1, 0, 2, 16'h9646);
    push_beat(0, 0, 2, 16'h9646);
    push_beat(0, 0, 2, 16'h0800);
    push_beat(0, 1, 2, 16'h0000);
    send_cmd(16'd0);
    wait_drain();
    check("t27_cmd_rdy", cmd_rdy_o, 1);
    check("t27_idle", fsm_state, ST_IDLE);

    // pay_len 3 with a 2-cycle stall on header beat 2
    push_beat(1, 0, 2, 16'h9646);
    push_beat(0, 0, 2, 16'h9646);
    push_beat(0, 0, 2, 16'h0B00);
    push_beat(0, 0, 2, 16'h0000);
    push_beat(0, 0, 2, 16'h2211);
    push_beat(0, 1, 1, 16'h0033);
    base = beat_cnt;
    send_cmd(16'd3);
    for (int i = 0; i < 20; i++) begin
      if (beat_cnt == base + 2) break;
      @(posedge clk); #1;
    end
    check("t28_reach_b2", beat_cnt - base, 2);
    ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t28_hold_data", data_o, 16'h0B00);
      check("t28_hold_valid", valid_o, 1);
      check("t28_hold_start", start_o, 0);
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    send_beat(16'h2211, 2'd2);
    send_beat(16'h0033, 2'd1);
    wait_drain();
    check("t28_beats", beat_cnt - base, 6);

    // cancel after 1 of 3 payload beats, then a fresh pay_len 0 datagram
    push_beat(1, 0, 2, 16'h9646);
    push_beat(0, 0, 2, 16'h9646);
    push_beat(0, 0, 2, 16'h0E00);
    push_beat(0, 0, 2, 16'h0000);
    push_beat(0, 0, 2, 16'h1111);
    send_cmd(16'd6);
    send_beat(16'h1111, 2'd2);
    check("t29_in_data", fsm_state, ST_DATA);
    cancel_i = 1'b1;
    @(posedge clk); #1;
    cancel_i = 1'b0;
    valid_i = 1'b1; data_i = 16'h2222; len_i = 2'd2;
    #1;
    check("t29_state", fsm_state, ST_IDLE);
    check("t29_valid", valid_o, 0);
    check("t29_ready", ready_o, 0);
    valid_i = 1'b0;
    push_beat(1, 0, 2, 16'h9646);
    push_beat(0, 0, 2, 16'h9646);
    push_beat(0, 0, 2, 16'h0800);
    push_beat(0, 1, 2, 16'h0000);
    send_cmd(16'd0);
    wait_drain();

    // reset during header beat 1
    push_beat(1, 0, 2, 16'h9646);
    base = beat_cnt;
    send_cmd(16'd2);
    for (int i = 0; i < 20; i++) begin
      if (beat_cnt == base + 1) break;
      @(posedge clk); #1;
    end
    check("t30_reach_b1", beat_cnt - base, 1);
    #1;
    nreset = 1'b0;
    #1;
    check("t30_valid", valid_o, 0);
    check("t30_cmd_rdy", cmd_rdy_o, 1);
    check("t30_start", start_o, 0);
    check("t30_last", last_o, 0);
    check("t30_state", fsm_state, ST_IDLE);
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("t30_no_beats", beat_cnt - base, 1);
    check("t30_q_empty", exp_q.size(), 0);

`ifdef UDP_TX_LEN_CHK_EN
    // overrun: second len-2 beat after a pay_len 2 datagram completed
    push_beat(1, 0, 2, 16'h9646);
    push_beat(0, 0, 2, 16'h9646);
    push_beat(0, 0, 2, 16'h0A00);
    push_beat(0, 0, 2, 16'h0000);
    push_beat(0, 1, 2, 16'h0201);
    send_cmd(16'd2);
    send_beat(16'h0201, 2'd2);
    valid_i = 1'b1; data_i = 16'h0403; len_i = 2'd2;
    @(posedge clk); #1;
    valid_i = 1'b0;
    check("t31_err", err_o, 1);
    check("t31_idle", fsm_state, ST_IDLE);
    push_beat(1, 0, 2, 16'h9646);
    push_beat(0, 0, 2, 16'h9646);
    push_beat(0, 0, 2, 16'h0800);
    push_beat(0, 1, 2, 16'h0000);
    send_cmd(16'd0);
    check("t31_err_clr", err_o, 0);
    wait_drain();
`else
    check("err_tied", err_o, 0);
`endif

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_tx.md
UDP_TX -- requirements
Module: udp_tx

Interface
REQ-001 SHALL have parameters: DATA_W, default 16, datapath width (only 16 supported); LEN_W, default $clog2(DATA_W/8)+1, byte-count width; PORT_W, default 16; SRC_PORT, default 16'd18070; DST_PORT, default 16'd18070.
REQ-002 SHALL have ports: clk  in  1  single clock; nreset  in  1  asynchronous active-low reset.
REQ-003 cmd_v_i  in  1  new datagram request; pay_len_i  in  16  payload bytes; cmd_rdy_o  out  1  request accepted when cmd_v_i & cmd_rdy_o.
REQ-004 valid_i  in  1  app payload beat valid; data_i  in  DATA_W  payload; len_i  in  LEN_W  valid bytes (1..2, data_i[7:0] first on wire); ready_o  out  1  app beat accepted when valid_i & ready_o.
REQ-005 valid_o  out  1; start_o  out  1  first header beat; data_o  out  DATA_W; len_o  out  LEN_W; last_o  out  1  final datagram beat; ready_i  in  1  downstream (IP tx) accepts when valid_o & ready_i.
REQ-006 cancel_i  in  1  abort current datagram; err_o  out  1  length-check error (see Configuration).

Function
REQ-007 SHALL implement one-hot FSM IDLE, HEAD, DATA.
REQ-008 IDLE: cmd_rdy_o=1, valid_o=0, ready_o=0; on cmd_v_i SHALL register pay_len_i and udp_len=pay_len_i+8 (mod 2^16), go HEAD.
REQ-009 HEAD: valid_o=1, len_o=2, ready_o=0; SHALL emit 4 beats, advancing only on ready_i: SRC_PORT, DST_PORT, udp_len, checksum 16'h0000.
REQ-010 Each header field SHALL be driven big-endian on the wire: data_o[7:0]=field[15:8], data_o[15:8]=field[7:0].
REQ-011 start_o SHALL be 1 only on header beat 0.
REQ-012 After header beat 3 accepted: pay_len=0 -> last_o=1 on beat 3 and return IDLE; otherwise go DATA.
REQ-013 DATA: valid_o=valid_i, ready_o=ready_i, data_o=data_i, len_o=len_i (combinational passthrough, zero latency); byte counter adds len_i per accepted beat.
REQ-014 last_o SHALL assert on the DATA beat where count+len_i >= pay_len; FSM returns IDLE when that beat is accepted.
REQ-015 Header stall: beat index and outputs SHALL hold while ready_i=0.
REQ-016 cancel_i SHALL force IDLE next cycle from any state, highest priority; in-flight beat not completed; counter cleared.
REQ-017 cmd_v_i outside IDLE SHALL be ignored (cmd_rdy_o=0).
REQ-018 Byte counter SHALL be 16 bits, saturating-free; comparison unsigned.

Reset
REQ-019 nreset low SHALL asynchronously force IDLE, header index 0, counter 0, err_o 0.
REQ-020 Outputs during/after reset: cmd_rdy_o=1, valid_o=0, ready_o=0, start_o=0, last_o=0, err_o=0.
REQ-021 Reset mid-datagram SHALL discard the datagram with no further output beats.

Configuration
REQ-022 Macro UDP_TX_LEN_CHK_EN: when defined, an app beat with valid_i in IDLE/HEAD, or len_i=0/len_i>2 in DATA, or count+len_i > pay_len, SHALL set err_o (sticky until next accepted cmd) and treat as cancel.
REQ-023 Without UDP_TX_LEN_CHK_EN, err_o SHALL be tied 0 and no checking logic synthesized; overrun bytes are truncated by last_o only.

Structure
REQ-024 Shared package udp_pkg SHALL hold UDP_HEAD_BYTES=8, default port constants, and FSM state encoding.
REQ-025 No sub-module; single module.

Verification
REQ-026 cmd pay_len=4, ready_i=1, two 2-byte beats 0x0201,0x0403 -> 6 beats: 0x9646,0x9646,0x0C00,0x0000,0x0201,0x0403; start_o on beat 0, last_o on beat 5.
REQ-027 pay_len=0 -> 4 header beats, udp_len beat 0x0800, last_o on beat 3, cmd_rdy_o=1 next cycle.
REQ-028 pay_len=3, beats len 2 then len 1, ready_i low 2 cycles during header beat 2 -> beat held stable, total 6 beats, last_o with len_o=1.
REQ-029 cancel_i during DATA after 1 of 3 payload beats -> IDLE next cycle, valid_o=0, new cmd accepted normally.
REQ-030 nreset asserted during HEAD beat 1 -> outputs at reset values immediately, no further beats.
REQ-031 With UDP_TX_LEN_CHK_EN, pay_len=2 and app sends 2 beats of len 2 -> err_o=1 on second beat, FSM IDLE, err_o clears on next cmd.
